fsm_key_driver: RTL

FSM_KEY_DRIVER -- requirements
Module: fsm_key_driver

---
 rtl/fsm_key_pkg.sv | 13 +
 rtl/keydrv_bit_cnt.sv | 36 +++
 rtl/fsm_key_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fsm_key_pkg.sv
// Shared types and defaults for the key driver: state encoding and the default unlock key.
package fsm_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PASS = 2'd2
    } keyState_t;

    localparam int          DEFAULT_KEY_LEN = 5;
    localparam logic [4:0]  DEFAULT_KEY     = 5'b11110;

endpackage

// File: rtl/keydrv_bit_cnt.sv
// Bit index counter for the key driver: synchronous clear, enable-gated increment,
// saturating at CNT_MAX-1 with a terminal-count flag.
module keydrv_bit_cnt #(
    parameter int CNT_MAX = 5,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CNT_MAX - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_atLast;

    assign w_atLast = (r_count == LAST_IDX);

    // Clear wins over enable; the count holds at the last index so it never overruns the key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_atLast) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = w_atLast;

endmodule

// File: rtl/fsm_key_driver.sv
// Serial key driver: shifts KEY out MSB first, then forwards data_in to the unlocked target.
// Optional macro FSM_KEY_DRIVER_ERRINJ_EN adds err_inj, which corrupts the final key bit.
module fsm_key_driver
    import fsm_key_pkg::*;
#(
    parameter int                 KEY_LEN = DEFAULT_KEY_LEN,
    parameter logic [KEY_LEN-1:0] KEY     = DEFAULT_KEY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic data_in,
    output logic x_out,
    output logic busy,
    output logic unlocked,
    output logic done,
    output logic aborted
`ifdef FSM_KEY_DRIVER_ERRINJ_EN
    ,
    input  logic err_inj
`endif
);

    localparam int IDX_W = $clog2(KEY_LEN + 1);

    keyState_t          r_state;
    keyState_t          w_nextState;
    logic               r_done;
    logic               r_aborted;
    logic               w_doneNext;
    logic               w_abortedNext;
    logic               w_cntClr;
    logic               w_cntEn;
    logic               w_startAccept;
    logic [IDX_W-1:0]   w_idx;
    logic               w_lastBit;
    logic [KEY_LEN-1:0] w_keyShifted;
    logic               w_keyBit;
    logic               w_errInj;

    keydrv_bit_cnt #(
        .CNT_MAX (KEY_LEN),
        .CNT_W   (IDX_W)
    ) u_bitCnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_cntClr),
        .i_en       (w_cntEn),
        .o_count    (w_idx),
        .o_terminal (w_lastBit)
    );

    assign w_startAccept = (r_state == IDLE) && start && !abort;

`ifdef FSM_KEY_DRIVER_ERRINJ_EN
    logic r_errInj;

    // The corruption request is captured with start and held for the whole transmission.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errInj <= 1'b0;
        end else if (w_startAccept) begin
            r_errInj <= err_inj;
        end
    end

    assign w_errInj = r_errInj;
`else
    assign w_errInj = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_done    <= w_doneNext;
            r_aborted <= w_abortedNext;
        end
    end

    // Abort is checked before the terminal count so it can cancel even the final bit.
    always_comb begin
        w_nextState   = r_state;
        w_doneNext    = 1'b0;
        w_abortedNext = 1'b0;
        w_cntClr      = 1'b0;
        w_cntEn       = 1'b0;
        case (r_state)
            IDLE: begin
                w_cntClr = 1'b1;
                if (w_startAccept) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    w_nextState   = IDLE;
                    w_abortedNext = 1'b1;
                end else if (w_lastBit) begin
                    w_nextState = PASS;
                    w_doneNext  = 1'b1;
                end else begin
                    w_cntEn = 1'b1;
                end
            end
            PASS: begin
                w_nextState = PASS;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_keyShifted = KEY << w_idx;
    assign w_keyBit     = w_keyShifted[KEY_LEN-1] ^ (w_errInj & w_lastBit);

    always_comb begin
        x_out    = 1'b0;
        busy     = 1'b0;
        unlocked = 1'b0;
        case (r_state)
            SEND: begin
                x_out = w_keyBit;
                busy  = 1'b1;
            end
            PASS: begin
                x_out    = data_in;
                unlocked = 1'b1;
            end
            default: begin
                x_out = 1'b0;
            end
        endcase
    end

    assign done    = r_done;
    assign aborted = r_aborted;

endmodule
